// File: rtl/muldiv_pkg.sv
// Shared op encoding, FSM state type and op-class helpers for the HI/LO multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OpMult  = 3'd0,
        OpMultu = 3'd1,
        OpDiv   = 3'd2,
        OpDivu  = 3'd3,
        OpMthi  = 3'd4,
        OpMtlo  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StFixup
    } state_e;

    function automatic logic is_mul(input logic [2:0] op);
        return (op == OpMult) || (op == OpMultu);
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return (op == OpDiv) || (op == OpDivu);
    endfunction

    function automatic logic is_signed(input logic [2:0] op);
        return (op == OpMult) || (op == OpDiv);
    endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division step: compare shifted partial remainder against divisor.
module muldiv_div_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN:0]   rem_i,
    input  logic [XLEN-1:0] div_i,
    output logic [XLEN-1:0] rem_o,
    output logic            q_o
);

    logic [XLEN-1:0] w_diff;

    // When the subtraction succeeds the true difference is below the divisor, so XLEN bits hold it.
    assign w_diff = rem_i[XLEN-1:0] - div_i;
    assign q_o    = (rem_i >= {1'b0, div_i});
    assign rem_o  = q_o ? w_diff : rem_i[XLEN-1:0];

endmodule

// File: rtl/muldiv_hilo.sv
// Iterative MUL/DIV unit with architectural HI/LO registers.
// Define MULDIV_FAST_MUL_EN to use a single-cycle multiplier for MULT/MULTU.
module muldiv_hilo
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs_i,
    input  logic [XLEN-1:0] rt_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    state_e           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  r_hi_acc, r_lo_acc, r_b, r_rs, r_hi, r_lo;
    logic             r_neg_lo, r_neg_hi, r_div0, r_is_div, r_busy, r_done;

    logic             w_go, w_last, w_sgn, w_rs_neg, w_rt_neg, w_div_q;
    logic [XLEN-1:0]  w_rs_mag, w_rt_mag, w_div_rem, w_hi_fix, w_lo_fix;
    logic [XLEN:0]    w_mul_sum;
    logic [2*XLEN-1:0] w_prod_fix;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] w_prod;
    assign w_prod = {{XLEN{1'b0}}, w_rs_mag} * {{XLEN{1'b0}}, w_rt_mag};
`endif

    assign w_go     = start_i && !flush_i && (r_state == StIdle);
    assign w_last   = (r_cnt == CNT_W'(XLEN - 1));
    assign w_sgn    = is_signed(op_i);
    assign w_rs_neg = w_sgn & rs_i[XLEN-1];
    assign w_rt_neg = w_sgn & rt_i[XLEN-1];
    assign w_rs_mag = w_rs_neg ? -rs_i : rs_i;
    assign w_rt_mag = w_rt_neg ? -rt_i : rt_i;

    // Shift-add: r_lo_acc holds unused multiplier bits below the growing low product half.
    assign w_mul_sum = {1'b0, r_hi_acc} + (r_lo_acc[0] ? {1'b0, r_b} : '0);

    muldiv_div_step #(
        .XLEN (XLEN)
    ) u_div_step (
        .rem_i ({r_hi_acc, r_lo_acc[XLEN-1]}),
        .div_i (r_b),
        .rem_o (w_div_rem),
        .q_o   (w_div_q)
    );

    assign w_prod_fix = r_neg_lo ? -{r_hi_acc, r_lo_acc} : {r_hi_acc, r_lo_acc};

    always_comb begin
        w_hi_fix = w_prod_fix[2*XLEN-1:XLEN];
        w_lo_fix = w_prod_fix[XLEN-1:0];
        if (r_is_div) begin
            if (r_div0) begin
                w_hi_fix = r_rs;
                w_lo_fix = '1;
            end else begin
                w_hi_fix = r_neg_hi ? -r_hi_acc : r_hi_acc;
                w_lo_fix = r_neg_lo ? -r_lo_acc : r_lo_acc;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_go && is_mul(op_i)) begin
`ifdef MULDIV_FAST_MUL_EN
                    w_state_nxt = StFixup;
`else
                    w_state_nxt = StMul;
`endif
                end else if (w_go && is_div(op_i)) begin
                    w_state_nxt = StDiv;
                end
            end
            StMul:   if (w_last) w_state_nxt = StFixup;
            StDiv:   if (w_last) w_state_nxt = StFixup;
            StFixup: w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
        if (flush_i) w_state_nxt = StIdle;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= StIdle;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_hi_acc <= '0;
            r_lo_acc <= '0;
            r_b      <= '0;
            r_rs     <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_div0   <= 1'b0;
            r_is_div <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (flush_i) begin
                r_busy <= 1'b0;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (start_i && (op_i == OpMthi)) begin
                            r_hi <= rs_i;
                        end else if (start_i && (op_i == OpMtlo)) begin
                            r_lo <= rs_i;
                        end else if (start_i && is_mul(op_i)) begin
                            r_busy   <= 1'b1;
                            r_cnt    <= '0;
                            r_is_div <= 1'b0;
                            r_div0   <= 1'b0;
                            r_neg_lo <= w_rs_neg ^ w_rt_neg;
                            r_b      <= w_rs_mag;
`ifdef MULDIV_FAST_MUL_EN
                            {r_hi_acc, r_lo_acc} <= w_prod;
`else
                            r_hi_acc <= '0;
                            r_lo_acc <= w_rt_mag;
`endif
                        end else if (start_i && is_div(op_i)) begin
                            r_busy   <= 1'b1;
                            r_cnt    <= '0;
                            r_is_div <= 1'b1;
                            r_div0   <= (rt_i == '0);
                            r_rs     <= rs_i;
                            r_neg_lo <= w_rs_neg ^ w_rt_neg;
                            r_neg_hi <= w_rs_neg;
                            r_b      <= w_rt_mag;
                            r_hi_acc <= '0;
                            r_lo_acc <= w_rs_mag;
                        end
                    end
                    StMul: begin
                        {r_hi_acc, r_lo_acc} <= {w_mul_sum, r_lo_acc[XLEN-1:1]};
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                    StDiv: begin
                        r_hi_acc <= w_div_rem;
                        r_lo_acc <= {r_lo_acc[XLEN-2:0], w_div_q};
                        r_cnt    <= r_cnt + CNT_W'(1);
                    end
                    StFixup: begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                        r_hi   <= w_hi_fix;
                        r_lo   <= w_lo_fix;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy_o = r_busy;
    assign done_o = r_done;
    assign hi_o   = r_hi;
    assign lo_o   = r_lo;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Self-checking bench for muldiv_hilo against an arithmetic HI/LO reference model.
module tb_muldiv_hilo;

    localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = XLEN + 1;
`endif
    localparam int DIV_LAT = XLEN + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs = 32'd0;
    logic [31:0] rt = 32'd0;
    logic        busy, done;
    logic [31:0] hi, lo;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    int          n_cmp = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    muldiv_hilo #(
        .XLEN (XLEN)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start),
        .op_i    (op),
        .rs_i    (rs),
        .rt_i    (rt),
        .flush_i (flush),
        .busy_o  (busy),
        .done_o  (done),
        .hi_o    (hi),
        .lo_o    (lo)
    );

    // Architectural effect of one completed instruction on HI/LO.
    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  inout logic [31:0] h, inout logic [31:0] l);
        longint sa, sb;
        logic [63:0] p;
        int ia, ib;
        case (o)
            3'd0: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p = 64'(sa * sb);
                {h, l} = p;
            end
            3'd1: begin
                p = {32'd0, a} * {32'd0, b};
                {h, l} = p;
            end
            3'd2: begin
                ia = $signed(a);
                ib = $signed(b);
                if (ib == 0) begin
                    l = 32'hFFFF_FFFF;
                    h = a;
                end else if (a == 32'h8000_0000 && ib == -1) begin
                    l = 32'h8000_0000;
                    h = 32'd0;
                end else begin
                    l = ia / ib;
                    h = ia % ib;
                end
            end
            3'd3: begin
                if (b == 32'd0) begin
                    l = 32'hFFFF_FFFF;
                    h = a;
                end else begin
                    l = a / b;
                    h = a % b;
                end
            end
            3'd4: h = a;
            3'd5: l = a;
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'd1;
            4: return 32'($urandom_range(0, 100));
            default: return $urandom;
        endcase
    endfunction

    // Drive one start strobe; returns just after the sampling edge E0.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op = o;
        rs = a;
        rt = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Edges after E0 until done_o is seen; -1 if it never comes.
    task automatic wait_done(output int n);
        n = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi); end
        n_cmp++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_hi = 32'd0;
        m_lo = 32'd0;
    endtask

    task automatic test_directed();
        logic [2:0]  t_op [5];
        logic [31:0] t_rs [5];
        logic [31:0] t_rt [5];
        int n, lat;
        t_op = '{3'd1, 3'd0, 3'd2, 3'd3, 3'd2};
        t_rs = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000};
        t_rt = '{32'hFFFF_FFFF, 32'd5, 32'd2, 32'd0, 32'hFFFF_FFFF};
        for (int i = 0; i < 5; i++) begin
            lat = (t_op[i] <= 3'd1) ? MUL_LAT : DIV_LAT;
            issue(t_op[i], t_rs[i], t_rt[i]);
            model(t_op[i], t_rs[i], t_rt[i], m_hi, m_lo);
            n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL dir_busy[%0d]: got %b want 1", i, busy); end
            wait_done(n);
            n_cmp++; if (n != lat) begin n_fail++; $display("FAIL dir_latency[%0d]: got %0d want %0d", i, n, lat); end
            n_cmp++; if (hi !== m_hi) begin n_fail++; $display("FAIL dir_hi[%0d]: got %h want %h", i, hi, m_hi); end
            n_cmp++; if (lo !== m_lo) begin n_fail++; $display("FAIL dir_lo[%0d]: got %h want %h", i, lo, m_lo); end
            n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dir_busy_end[%0d]: got %b want 0", i, busy); end
            @(posedge clk);
            #1;
            n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL dir_done_pulse[%0d]: got %b want 0", i, done); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        int n;
        a = $urandom;
        b = 32'($urandom_range(1, 1000));
        issue(3'd2, a, b);
        model(3'd2, a, b, m_hi, m_lo);
        wait_done(n);
        n_cmp++; if (n != DIV_LAT) begin n_fail++; $display("FAIL b2b_latency0: got %0d want %0d", n, DIV_LAT); end
        // Restart in the very cycle done_o is high.
        a = $urandom;
        b = $urandom;
        op = 3'd0;
        rs = a;
        rt = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b want 1", busy); end
        model(3'd0, a, b, m_hi, m_lo);
        wait_done(n);
        n_cmp++; if (n != MUL_LAT) begin n_fail++; $display("FAIL b2b_latency1: got %0d want %0d", n, MUL_LAT); end
        n_cmp++; if (hi !== m_hi) begin n_fail++; $display("FAIL b2b_hi: got %h want %h", hi, m_hi); end
        n_cmp++; if (lo !== m_lo) begin n_fail++; $display("FAIL b2b_lo: got %h want %h", lo, m_lo); end
    endtask

    task automatic test_flush();
        int dones;
        issue(3'd3, 32'h1234_5678, 32'd3);
        repeat (4) @(posedge clk);
        // A start mid-operation must be ignored.
        @(negedge clk);
        op = 3'd4;
        rs = 32'hDEAD_BEEF;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n_cmp++; if (hi !== m_hi) begin n_fail++; $display("FAIL flush_ignored_start: got %h want %h", hi, m_hi); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_busy_mid: got %b want 1", busy); end
        repeat (4) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b want 0", busy); end
        dones = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        n_cmp++; if (dones != 0) begin n_fail++; $display("FAIL flush_done: got %0d pulses want 0", dones); end
        n_cmp++; if (hi !== m_hi) begin n_fail++; $display("FAIL flush_hi: got %h want %h", hi, m_hi); end
        n_cmp++; if (lo !== m_lo) begin n_fail++; $display("FAIL flush_lo: got %h want %h", lo, m_lo); end
        // Flush and start together: the start is dropped.
        @(negedge clk);
        op = 3'd4;
        rs = 32'h5555_5555;
        start = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        flush = 1'b0;
        n_cmp++; if (hi !== m_hi) begin n_fail++; $display("FAIL flush_start_hi: got %h want %h", hi, m_hi); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_start_busy: got %b want 0", busy); end
    endtask

    task automatic test_mt_and_reset();
        issue(3'd4, 32'h0000_1234, 32'd0);
        model(3'd4, 32'h0000_1234, 32'd0, m_hi, m_lo);
        n_cmp++; if (hi !== m_hi) begin n_fail++; $display("FAIL mthi_hi: got %h want %h", hi, m_hi); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mthi_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL mthi_done: got %b want 0", done); end
        issue(3'd5, 32'hCAFE_0001, 32'd0);
        model(3'd5, 32'hCAFE_0001, 32'd0, m_hi, m_lo);
        n_cmp++; if (lo !== m_lo) begin n_fail++; $display("FAIL mtlo_lo: got %h want %h", lo, m_lo); end
        issue(3'd1, $urandom, $urandom);
        #2 rst_n = 1'b0;
        #1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        n_cmp++; if (hi !== m_hi) begin n_fail++; $display("FAIL rst_mid_hi: got %h want %h", hi, m_hi); end
        n_cmp++; if (lo !== m_lo) begin n_fail++; $display("FAIL rst_mid_lo: got %h want %h", lo, m_lo); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] a, b;
        int n, lat;
        for (int i = 0; i < 24; i++) begin
            o = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            issue(o, a, b);
            model(o, a, b, m_hi, m_lo);
            if (o <= 3'd3) begin
                lat = (o <= 3'd1) ? MUL_LAT : DIV_LAT;
                n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rnd_busy[%0d]: got %b want 1", i, busy); end
                wait_done(n);
                n_cmp++; if (n != lat) begin n_fail++; $display("FAIL rnd_latency[%0d] op%0d: got %0d want %0d", i, o, n, lat); end
            end else begin
                n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rnd_busy_mt[%0d]: got %b want 0", i, busy); end
            end
            n_cmp++; if (hi !== m_hi) begin n_fail++; $display("FAIL rnd_hi[%0d] op%0d %h,%h: got %h want %h", i, o, a, b, hi, m_hi); end
            n_cmp++; if (lo !== m_lo) begin n_fail++; $display("FAIL rnd_lo[%0d] op%0d %h,%h: got %h want %h", i, o, a, b, lo, m_lo); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_flush();
        test_mt_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/muldiv_hilo.md
# muldiv_hilo

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS core. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO issued by the decode/execute stage, and holds the result in HI/LO for MFHI/MFLO. The operand width is parametrised, and the unit raises `busy_o` so the pipeline can stall while an operation is in flight. It sits beside the ALU in EX and is driven by the control decoder's HI/LO write-enable decode.

## Interface
- `XLEN`, default 32 – operand width and HI/LO register width.
- `CNT_W`, default `$clog2(XLEN)+1` – width of the iteration counter.

Ports:
- `clk`  in  1  – clock; all state changes on the rising edge.
- `rst_n`  in  1  – one clock; reset is asynchronous and active-low.
- `start_i`  in  1  – issue strobe; sampled only in IDLE.
- `op_i`  in  3  – operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 are ignored.
- `rs_i`  in  XLEN  – multiplicand, dividend, or MT source.
- `rt_i`  in  XLEN  – multiplier or divisor.
- `flush_i`  in  1  – abort any in-flight operation.
- `busy_o`  out  1  – an operation is in flight.
- `done_o`  out  1  – one-cycle pulse; HI/LO just updated by a MUL/DIV.
- `hi_o`  out  XLEN  – HI register.
- `lo_o`  out  XLEN  – LO register.

## Operation
- States: IDLE, MUL, DIV, FIXUP.
- IDLE with `start_i` and a MUL/DIV op:
  - Latch operand magnitudes and the signs needed for the op.
  - Clear the counter.
  - Go to MUL or DIV.
- IDLE with `start_i` and MTHI/MTLO: write `rs_i` to HI/LO at that edge. No busy, no done.
- MUL: shift-add, one multiplier bit per cycle, for XLEN cycles, then go to FIXUP.
- DIV: restoring division, one quotient bit per cycle, for XLEN cycles, then go to FIXUP.
- FIXUP:
  - Apply sign correction.
  - Write HI/LO.
  - Pulse `done_o`.
  - Return to IDLE.
- Multiply result: the 2·XLEN-bit product, with HI as the upper half and LO as the lower half.
- Signed divide:
  - Quotient truncates toward zero and goes to LO.
  - Remainder takes the sign of the dividend and goes to HI.
- Divide by zero (signed or unsigned): LO = all ones, HI = `rs_i`.
- Signed divide of minimum value by −1: LO = minimum value, HI = 0. This is the natural two's-complement wrap; no trap.
- HI/LO keep their old values until FIXUP. MFHI/MFLO issued while `busy_o` is high must be stalled by the pipeline.
- `start_i` while not in IDLE is ignored.
- `flush_i`:
  - Forces IDLE at the next edge.
  - HI/LO are unchanged and no `done_o` is produced.
  - If `flush_i` and `start_i` are in the same cycle, flush wins and start is dropped.
- Reset: state IDLE, `hi_o` = 0, `lo_o` = 0, `busy_o` = 0, `done_o` = 0, counter 0.
- Reset mid-operation discards the operation.

## Timing
- Let E0 be the edge that samples `start_i`.
- `busy_o` is high from E0 until the edge that writes HI/LO.
- Iterative path: HI/LO are written and `done_o` goes high after edge E0+XLEN+1. `busy_o` falls at that same edge.
  - Latency is 33 cycles for XLEN=32.
- `done_o` is high for exactly one cycle.
- A new `start_i` may be asserted in the same cycle as `done_o`.
- MTHI/MTLO: the new value is visible on `hi_o`/`lo_o` after E0. `busy_o` stays low.
- All outputs are registered.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MULT/MULTU use a single-cycle combinational multiplier and go IDLE→FIXUP directly.
  - HI/LO are written and `done_o` pulses after E0+1.
  - `busy_o` is high for one cycle.
- `MULDIV_FAST_MUL_EN` undefined: the iterative MUL state is used, with latency XLEN+1.
- Division is always iterative.

## Structure
- Package `muldiv_pkg` holds:
  - The `op_i` encoding as a typedef enum.
  - The FSM state typedef.
  - The op-class helper functions `is_mul`, `is_div`, `is_signed`.
- Sub-module `muldiv_div_step`: combinational single restoring-division step (partial remainder and divisor in; next remainder and quotient bit out).
- The FSM, counter and HI/LO registers live in the top module.

## Test plan
All scenarios use XLEN=32. "Iterative done after E0+33" means `done_o` pulses after edge E0+33; with `MULDIV_FAST_MUL_EN` defined, multiply done moves to after E0+1.
1. MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. Iterative: done after E0+33. Fast: done after E0+1.
2. MULT 0xFFFFFFFD (−3) × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
3. DIV 0xFFFFFFF9 (−7) ÷ 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7 ÷ 0 → LO=0xFFFFFFFF, HI=0x00000007.
4. DIV 0x80000000 ÷ 0xFFFFFFFF → LO=0x80000000, HI=0x00000000, no hang. Done after E0+33.
5. DIVU started, then `flush_i` at cycle 10 → `busy_o` low next cycle, no `done_o`, HI/LO keep their prior values. A `start_i` at cycle 5 of the operation is ignored.
6. MTHI 0x00001234 → `hi_o`=0x00001234 after one edge, `busy_o` stays 0. Then `rst_n` low mid-MULTU → HI/LO=0, `busy_o`=0 immediately.
